// File: rtl/sm_regdump_uart_pkg.sv
// Shared constants for the register-dump engine: FSM encodings, ASCII codes,
// record lengths for both record formats, and the nibble-to-ASCII helper.
package sm_regdump_uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_SEND   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam logic [3:0] REC_LEN_PLAIN = 4'd10;
  localparam logic [3:0] REC_LEN_INDEX = 4'd13;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] r;
    if (nib < 4'd10) begin
      r = ASCII_0 + {4'd0, nib};
    end else begin
      r = ASCII_A + {4'd0, nib} - 8'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// 8N1 UART transmitter. txBusy drops in the last stop-bit cycle so the parent
// can hand over the next byte and keep frames back-to-back.
module sm_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       tx
);

  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_s;
  logic        accept_s;

  assign last_s   = busy_q && (bit_q == 4'd9) && (baud_q == 16'(BAUD_DIV - 1));
  assign txBusy   = busy_q && !last_s;
  assign accept_s = txStart && !txBusy;
  assign tx       = tx_q;

  // Bit index 0 is the start bit, 1..8 data, 9 stop; output changes at each bit end.
  always_comb begin
    busy_d  = busy_q;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (accept_s) begin
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      baud_d  = 16'd0;
      bit_d   = 4'd0;
      shift_d = txData;
    end else if (busy_q) begin
      if (baud_q == 16'(BAUD_DIV - 1)) begin
        baud_d = 16'd0;
        bit_d  = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else if (bit_q == 4'd8) begin
          tx_d = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      baud_q  <= 16'd0;
      bit_q   <= 4'd0;
      shift_q <= 8'd0;
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/sm_regdump_uart.sv
// Debug register-dump engine: walks indices 0..31 and prints each value as hex
// text over UART. Define SM_REGDUMP_INDEX_EN to prefix each record with "II:".
module sm_regdump_uart
  import sm_regdump_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef SM_REGDUMP_INDEX_EN
  localparam logic [3:0] REC_LEN   = REC_LEN_INDEX;
  localparam logic [2:0] DIGIT_OFS = 3'd3;
`else
  localparam logic [3:0] REC_LEN   = REC_LEN_PLAIN;
  localparam logic [2:0] DIGIT_OFS = 3'd0;
`endif

  logic [2:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] cap_q, cap_d;
  logic [3:0]  byte_q, byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tx_start_s;
  logic        tx_busy_s;
  logic [7:0]  tx_byte_s;
  logic [31:0] word_s;
  logic [3:0]  sel_s;
  logic [2:0]  digit_s;
  logic [4:0]  pos_s;

  assign regAddr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Byte 0 leaves during SAMPLE, straight from regData, to make the start bit land at S+3.
  always_comb begin
    word_s    = (state_q == ST_SAMPLE) ? regData : cap_q;
    sel_s     = (state_q == ST_SAMPLE) ? 4'd0 : byte_q;
    digit_s   = sel_s[2:0] - DIGIT_OFS;
    pos_s     = 5'd28 - {digit_s, 2'b00};
    tx_byte_s = hex_ascii(word_s[pos_s +: 4]);
    if (sel_s == REC_LEN - 4'd2) begin
      tx_byte_s = ASCII_CR;
    end else if (sel_s == REC_LEN - 4'd1) begin
      tx_byte_s = ASCII_LF;
`ifdef SM_REGDUMP_INDEX_EN
    end else if (sel_s == 4'd0) begin
      tx_byte_s = hex_ascii({3'b000, addr_q[4]});
    end else if (sel_s == 4'd1) begin
      tx_byte_s = hex_ascii(addr_q[3:0]);
    end else if (sel_s == 4'd2) begin
      tx_byte_s = ASCII_COLON;
`endif
    end else begin
      tx_byte_s = hex_ascii(word_s[pos_s +: 4]);
    end
  end

  // Dump sequencer; byte_q counts bytes already handed to the transmitter.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cap_d      = cap_q;
    byte_d     = byte_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          addr_d  = 5'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cap_d      = regData;
        tx_start_s = 1'b1;
        byte_d     = 4'd1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy_s) begin
          if (byte_q == REC_LEN) begin
            state_d = ST_NEXT;
            done_d  = (addr_q == 5'd31);
          end else begin
            tx_start_s = 1'b1;
            byte_d     = byte_q + 4'd1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        if (addr_q == 5'd31) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          addr_d  = addr_q + 5'd1;
          state_d = ST_ADDR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 5'd0;
      cap_q   <= 32'd0;
      byte_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cap_q   <= cap_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sm_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .txStart(tx_start_s),
    .txData (tx_byte_s),
    .txBusy (tx_busy_s),
    .tx     (tx)
  );

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Scoreboard bench for sm_regdump_uart: register-file model, UART receiver monitor,
// expected record bytes queued at each start. Honours SM_REGDUMP_INDEX_EN.
module tb_sm_regdump_uart;

  localparam int B = 4;
`ifdef SM_REGDUMP_INDEX_EN
  localparam int REC = 13;
`else
  localparam int REC = 10;
`endif
  localparam int P = REC * 10 * B + 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] reg_file [32];
  logic        perturb_en;
  logic [31:0] perturb_val;
  logic        perturb_arm;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rst_gen = 0;
  int rx_cnt  = 0;
  int extra_cnt = 0;
  int done_cnt  = 0;
  int first_fall = 0;
  logic fall_arm = 1'b0;
  logic [7:0] exp_q [$];

  assign regData = perturb_en ? perturb_val : reg_file[regAddr];

  sm_regdump_uart #(.BAUD_DIV(B)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .regAddr(regAddr),
    .regData(regData),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  task automatic push_dump();
    logic [31:0] v;
    logic [7:0]  ix;
    for (int i = 0; i < 32; i++) begin
      v  = reg_file[i];
      ix = 8'(i);
`ifdef SM_REGDUMP_INDEX_EN
      exp_q.push_back(to_hex(ix[7:4]));
      exp_q.push_back(to_hex(ix[3:0]));
      exp_q.push_back(8'h3A);
`endif
      for (int d = 7; d >= 0; d--) exp_q.push_back(to_hex(v[4*d +: 4]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      wait_cycles(1);
      if (done === 1'b1) seen = 1;
    end
  endtask

  // UART receiver: samples each bit in its middle, discards frames cut by reset.
  initial begin
    logic [7:0] rx;
    logic       stop;
    int         gen0;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        gen0 = rst_gen;
        if (fall_arm) begin
          first_fall = cyc;
          fall_arm = 1'b0;
        end
        wait_cycles(B + B / 2);
        for (int i = 0; i < 8; i++) begin
          rx[i] = tx;
          if (i < 7) wait_cycles(B);
        end
        wait_cycles(B);
        stop = tx;
        if (gen0 == rst_gen) begin
          check("stop_bit", 32'(stop), 32'd1);
          rx_cnt++;
          if (exp_q.size() > 0) check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          else extra_cnt++;
        end
      end
    end
  end

  // Rewrites regData for index 3 every cycle after its capture.
  initial begin
    perturb_en  = 1'b0;
    perturb_val = 32'd0;
    perturb_arm = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (perturb_arm && busy === 1'b1 && regAddr === 5'd3) begin
        perturb_arm = 1'b0;
        wait_cycles(2);
        perturb_en = 1'b1;
        for (int k = 0; k < 2 * P && regAddr === 5'd3; k++) begin
          perturb_val = $urandom;
          wait_cycles(1);
        end
        perturb_en = 1'b0;
      end
    end
  end

  initial begin
    int s, d, seen, viol, r;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 32; i++) reg_file[i] = 32'(i);
    reg_file[0]  = 32'h0000_0010;
    reg_file[5]  = 32'hDEAD_BEEF;
    reg_file[31] = 32'h0000_002A;
    wait_cycles(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(regAddr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_cycles(1);
      if (tx !== 1'b1 || busy !== 1'b0 || regAddr !== 5'd0 || done !== 1'b0) viol++;
    end
    check("idle_hold", 32'(viol), 32'd0);

    // Dump 1: perturbed index 3, start re-pulsed mid-dump and on the done cycle.
    push_dump();
    fall_arm = 1'b1;
    perturb_arm = 1'b1;
    start = 1'b1;
    s = cyc;
    wait_cycles(1);
    start = 1'b0;
    check("d1_busy_s1", 32'(busy), 32'd1);
    check("d1_addr_s1", 32'(regAddr), 32'd0);
    wait_cycles(5000);
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_done(32 * P, seen);
    check("d1_done_seen", 32'(seen), 32'd1);
    d = cyc;
    start = 1'b1;
    check("d1_done_cycle", 32'(d - s), 32'(32 * P));
    check("d1_first_fall", 32'(first_fall - s), 32'd3);
    check("d1_bytes", 32'(rx_cnt), 32'(32 * REC));
    check("d1_leftover", 32'(exp_q.size()), 32'd0);

    // Dump 2: start held into the cycle after done, then reset mid-byte of record 7.
    wait_cycles(1);
    check("d1_busy_after", 32'(busy), 32'd0);
    check("d1_done_count", 32'(done_cnt), 32'd1);
    rx_cnt = 0;
    push_dump();
    s = cyc;
    wait_cycles(1);
    start = 1'b0;
    check("d2_busy_s1", 32'(busy), 32'd1);
    check("d2_addr_s1", 32'(regAddr), 32'd0);
    r = s + 3 + 7 * P + 20 * B + 1;
    wait_cycles(r - cyc);
    check("d2_pre_rst_tx", 32'(tx), 32'd0);
    check("d2_pre_rst_addr", 32'(regAddr), 32'd7);
    #1;
    rst_n = 1'b0;
    rst_gen++;
    #1;
    check("d2_rst_tx", 32'(tx), 32'd1);
    check("d2_rst_busy", 32'(busy), 32'd0);
    check("d2_bytes", 32'(rx_cnt), 32'(7 * REC + 2));
    exp_q.delete();
    wait_cycles(50);
    rst_n = 1'b1;
    wait_cycles(3);
    check("d2_post_addr", 32'(regAddr), 32'd0);
    check("d2_post_busy", 32'(busy), 32'd0);

    // Dump 3: clean restart from index 0.
    rx_cnt = 0;
    done_cnt = 0;
    push_dump();
    fall_arm = 1'b1;
    start = 1'b1;
    s = cyc;
    wait_cycles(1);
    start = 1'b0;
    check("d3_addr_s1", 32'(regAddr), 32'd0);
    wait_done(32 * P + 100, seen);
    check("d3_done_seen", 32'(seen), 32'd1);
    check("d3_done_cycle", 32'(cyc - s), 32'(32 * P));
    check("d3_first_fall", 32'(first_fall - s), 32'd3);
    wait_cycles(10);
    check("d3_bytes", 32'(rx_cnt), 32'(32 * REC));
    check("d3_leftover", 32'(exp_q.size()), 32'd0);
    check("d3_done_count", 32'(done_cnt), 32'd1);
    check("d3_busy_end", 32'(busy), 32'd0);
    check("extra_bytes", 32'(extra_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
